// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
// opcode/funct codes, FSM state enum, aluop and alucontrol encodings.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] AC_ADD = 3'b010;
    localparam logic [2:0] AC_SUB = 3'b110;
    localparam logic [2:0] AC_AND = 3'b000;
    localparam logic [2:0] AC_OR  = 3'b001;
    localparam logic [2:0] AC_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_LOGIC = 2'b11
    } aluop_t;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, IMMEX, IMMWB, JEX
    } state_t;

endpackage

// File: rtl/mc_controller_if.sv
// Control-unit bus: instruction fields and status in, datapath controls out.
// master = datapath side, slave = controller side.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       zeroimm;
    logic       pcen;
    logic       illegal;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;

    modport master (
        output op, funct, zero, mem_ready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
        input  alusrca, zeroimm, pcen, illegal, alusrcb, pcsrc, alucontrol
    );

    modport slave (
        input  op, funct, zero, mem_ready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
        output alusrca, zeroimm, pcen, illegal, alusrcb, pcsrc, alucontrol
    );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop (+funct / op[0]) to the 3-bit ALU control.
// Ports: i_funct, i_aluop, i_op0 in; o_alucontrol out.
module mc_aludec
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    input  aluop_t     i_aluop,
    input  logic       i_op0,
    output logic [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = AC_ADD;
        unique case (i_aluop)
            ALU_ADD:   o_alucontrol = AC_ADD;
            ALU_SUB:   o_alucontrol = AC_SUB;
            // andi vs ori differ only in op[0]
            ALU_LOGIC: o_alucontrol = i_op0 ? AC_OR : AC_AND;
            ALU_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alucontrol = AC_ADD;
                    FN_SUB:  o_alucontrol = AC_SUB;
                    FN_AND:  o_alucontrol = AC_AND;
                    FN_OR:   o_alucontrol = AC_OR;
                    FN_SLT:  o_alucontrol = AC_SLT;
                    default: o_alucontrol = AC_ADD;
                endcase
            end
            default: o_alucontrol = AC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory handshake and illegal-op flag.
// Ports: clk, reset_n (async active-low), bus (mc_controller_if.slave).
module mc_controller
    import mips_pkg::*;
#(
    parameter bit ENABLE_BNE     = 1'b1,
    parameter bit ENABLE_ZEROIMM = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mc_controller_if.slave        bus
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;

    logic       w_ldst, w_rtype, w_beq, w_bne, w_br;
    logic       w_logic, w_imm, w_jmp, w_bad;
    logic       w_iord, w_memwrite, w_irwrite, w_regdst;
    logic       w_memtoreg, w_regwrite, w_alusrca, w_zeroimm;
    logic       w_pcwrite, w_branch, w_bne_s;
    logic [1:0] w_alusrcb, w_pcsrc;
    aluop_t     w_aluop;

    assign w_ldst  = (bus.op == OP_LW) || (bus.op == OP_SW);
    assign w_rtype = (bus.op == OP_R);
    assign w_beq   = (bus.op == OP_BEQ);
    assign w_bne   = ENABLE_BNE && (bus.op == OP_BNE);
    assign w_br    = w_beq || w_bne;
    assign w_logic = ENABLE_ZEROIMM &&
                     ((bus.op == OP_ANDI) || (bus.op == OP_ORI));
    assign w_imm   = (bus.op == OP_ADDI) || w_logic;
    assign w_jmp   = (bus.op == OP_J);
    assign w_bad   = !(w_ldst || w_rtype || w_br || w_imm || w_jmp);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FETCH:   if (bus.mem_ready) w_next = DECODE;
            DECODE: begin
                unique case (1'b1)
                    w_ldst:  w_next = MEMADR;
                    w_rtype: w_next = RTYPEEX;
                    w_br:    w_next = BEQEX;
                    w_imm:   w_next = IMMEX;
                    w_jmp:   w_next = JEX;
                    default: w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = (bus.op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (bus.mem_ready) w_next = MEMWB;
            MEMWB:   w_next = FETCH;
            MEMWR:   if (bus.mem_ready) w_next = FETCH;
            RTYPEEX: w_next = RTYPEWB;
            RTYPEWB: w_next = FETCH;
            BEQEX:   w_next = FETCH;
            IMMEX:   w_next = IMMWB;
            IMMWB:   w_next = FETCH;
            JEX:     w_next = FETCH;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            // set for the single cycle following a bad DECODE
            r_illegal <= (r_state == DECODE) && w_bad;
        end
    end

    always_comb begin
        w_iord     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_zeroimm  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_bne_s    = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsrc    = 2'b00;
        w_aluop    = ALU_ADD;
        unique case (r_state)
            FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
            end
            DECODE:  w_alusrcb = 2'b11;
            MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            MEMRD:   w_iord = 1'b1;
            MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = ALU_FUNCT;
            end
            RTYPEWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            BEQEX: begin
                w_alusrca = 1'b1;
                w_aluop   = ALU_SUB;
                w_pcsrc   = 2'b01;
                w_branch  = w_beq;
                w_bne_s   = w_bne;
            end
            IMMEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_aluop   = w_logic ? ALU_LOGIC : ALU_ADD;
                w_zeroimm = w_logic;
            end
            // keep the logic-op selection stable through writeback
            IMMWB: begin
                w_regwrite = 1'b1;
                w_aluop    = w_logic ? ALU_LOGIC : ALU_ADD;
                w_zeroimm  = w_logic;
            end
            JEX: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    mc_aludec u_aludec (
        .i_funct      (bus.funct),
        .i_aluop      (w_aluop),
        .i_op0        (bus.op[0]),
        .o_alucontrol (bus.alucontrol)
    );

    // write enables are gated by reset_n so they drop with reset,
    // independent of mem_ready
    assign bus.iord     = w_iord;
    assign bus.memwrite = w_memwrite & reset_n;
    assign bus.irwrite  = w_irwrite & reset_n;
    assign bus.regdst   = w_regdst;
    assign bus.memtoreg = w_memtoreg;
    assign bus.regwrite = w_regwrite & reset_n;
    assign bus.alusrca  = w_alusrca;
    assign bus.zeroimm  = w_zeroimm;
    assign bus.alusrcb  = w_alusrcb;
    assign bus.pcsrc    = w_pcsrc;
    assign bus.illegal  = r_illegal;
    assign bus.pcen     = reset_n & (w_pcwrite |
                                     (w_branch & bus.zero) |
                                     (w_bne_s & ~bus.zero));

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: default build plus a build with
// ENABLE_ZEROIMM=0, both fed the same stimulus.
module tb_mc_controller;
    import mips_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mc_controller_if bus0 ();
    mc_controller_if bus1 ();

    assign bus0.op        = op;
    assign bus0.funct     = funct;
    assign bus0.zero      = zero;
    assign bus0.mem_ready = mem_ready;
    assign bus1.op        = op;
    assign bus1.funct     = funct;
    assign bus1.zero      = zero;
    assign bus1.mem_ready = mem_ready;

    mc_controller u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    mc_controller #(.ENABLE_ZEROIMM(1'b0)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags: iord memwrite irwrite regdst memtoreg regwrite
    //        alusrca zeroimm pcen illegal | alusrcb pcsrc alucontrol
    function automatic logic [16:0] obs0();
        return {bus0.iord, bus0.memwrite, bus0.irwrite, bus0.regdst,
                bus0.memtoreg, bus0.regwrite, bus0.alusrca,
                bus0.zeroimm, bus0.pcen, bus0.illegal,
                bus0.alusrcb, bus0.pcsrc, bus0.alucontrol};
    endfunction

    task automatic check(input string tag, input logic [16:0] got,
                         input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] o,
                        input logic [5:0] f, input logic z,
                        input logic mr, input logic [16:0] exp);
        @(negedge clk);
        op = o; funct = f; zero = z; mem_ready = mr;
        #1;
        check(tag, obs0(), exp);
    endtask

    localparam logic [16:0] V_FETCH   = {10'b0010000010, 2'b01, 2'b00, 3'b010};
    localparam logic [16:0] V_FHOLD   = {10'b0000000000, 2'b01, 2'b00, 3'b010};
    localparam logic [16:0] V_FILL    = {10'b0010000011, 2'b01, 2'b00, 3'b010};
    localparam logic [16:0] V_DECODE  = {10'b0000000000, 2'b11, 2'b00, 3'b010};
    localparam logic [16:0] V_MEMADR  = {10'b0000001000, 2'b10, 2'b00, 3'b010};
    localparam logic [16:0] V_MEMRD   = {10'b1000000000, 2'b00, 2'b00, 3'b010};
    localparam logic [16:0] V_MEMWB   = {10'b0000110000, 2'b00, 2'b00, 3'b010};
    localparam logic [16:0] V_MEMWR   = {10'b1100000000, 2'b00, 2'b00, 3'b010};
    localparam logic [16:0] V_RTEX    = {10'b0000001000, 2'b00, 2'b00, 3'b110};
    localparam logic [16:0] V_BR_T    = {10'b0000001010, 2'b00, 2'b01, 3'b110};
    localparam logic [16:0] V_BR_N    = {10'b0000001000, 2'b00, 2'b01, 3'b110};
    localparam logic [16:0] V_IMMEX   = {10'b0000001100, 2'b10, 2'b00, 3'b001};
    localparam logic [16:0] V_IMMWB   = {10'b0000010100, 2'b00, 2'b00, 3'b001};
    localparam logic [16:0] V_JEX     = {10'b0000000010, 2'b00, 2'b10, 3'b010};

    initial begin
        reset_n = 1'b0; op = OP_LW; funct = 6'd0;
        zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", obs0(), V_FHOLD);
        check("reset_illegal1", {16'd0, bus1.illegal}, 17'd0);

        // lw, mem_ready=1: 5 cycles
        @(negedge clk); reset_n = 1'b1;
        #1 check("lw_fetch", obs0(), V_FETCH);
        step("lw_decode", OP_LW, 6'd0, 1'b0, 1'b1, V_DECODE);
        step("lw_memadr", OP_LW, 6'd0, 1'b0, 1'b1, V_MEMADR);
        step("lw_memrd",  OP_LW, 6'd0, 1'b0, 1'b1, V_MEMRD);
        step("lw_memwb",  OP_LW, 6'd0, 1'b0, 1'b1, V_MEMWB);

        // sw with three wait cycles in MEMWR
        step("sw_fetch",  OP_SW, 6'd0, 1'b0, 1'b1, V_FETCH);
        step("sw_decode", OP_SW, 6'd0, 1'b0, 1'b1, V_DECODE);
        step("sw_memadr", OP_SW, 6'd0, 1'b0, 1'b1, V_MEMADR);
        for (int i = 0; i < 3; i++)
            step("sw_memwr_wait", OP_SW, 6'd0, 1'b0, 1'b0, V_MEMWR);
        step("sw_memwr_done", OP_SW, 6'd0, 1'b0, 1'b1, V_MEMWR);

        // fetch stalls without mem_ready, then beq taken
        step("fetch_hold",  OP_BEQ, 6'd0, 1'b1, 1'b0, V_FHOLD);
        step("beq_fetch",   OP_BEQ, 6'd0, 1'b1, 1'b1, V_FETCH);
        step("beq_decode",  OP_BEQ, 6'd0, 1'b1, 1'b1, V_DECODE);
        step("beq_z1",      OP_BEQ, 6'd0, 1'b1, 1'b1, V_BR_T);

        step("bne_fetch",   OP_BNE, 6'd0, 1'b1, 1'b1, V_FETCH);
        step("bne_decode",  OP_BNE, 6'd0, 1'b1, 1'b1, V_DECODE);
        step("bne_z1",      OP_BNE, 6'd0, 1'b1, 1'b1, V_BR_N);
        step("bne_fetch2",  OP_BNE, 6'd0, 1'b0, 1'b1, V_FETCH);
        step("bne_decode2", OP_BNE, 6'd0, 1'b0, 1'b1, V_DECODE);
        step("bne_z0",      OP_BNE, 6'd0, 1'b0, 1'b1, V_BR_T);

        // R-type sub, then asynchronous reset inside RTYPEEX
        step("r_fetch",  OP_R, FN_SUB, 1'b0, 1'b1, V_FETCH);
        step("r_decode", OP_R, FN_SUB, 1'b0, 1'b1, V_DECODE);
        step("r_ex_sub", OP_R, FN_SUB, 1'b0, 1'b1, V_RTEX);
        #2 reset_n = 1'b0;
        #1 check("async_reset", obs0(), V_FHOLD);
        @(negedge clk); reset_n = 1'b1; op = 6'b111111;
        #1 check("fetch_after_rst", obs0(), V_FETCH);

        // undefined opcode: one-cycle illegal pulse, back to FETCH
        step("bad_decode", 6'b111111, 6'd0, 1'b0, 1'b1, V_DECODE);
        step("bad_fetch",  OP_J, 6'd0, 1'b0, 1'b1, V_FILL);
        step("j_decode",   OP_J, 6'd0, 1'b0, 1'b1, V_DECODE);
        step("j_jex",      OP_J, 6'd0, 1'b0, 1'b1, V_JEX);

        // ori: executed by default build, illegal with zeroimm disabled
        step("ori_fetch",  OP_ORI, 6'd0, 1'b0, 1'b1, V_FETCH);
        step("ori_decode", OP_ORI, 6'd0, 1'b0, 1'b1, V_DECODE);
        step("ori_immex",  OP_ORI, 6'd0, 1'b0, 1'b1, V_IMMEX);
        check("ori_off_ill", {15'd0, bus1.illegal, bus1.regwrite},
              17'b10);
        step("ori_immwb",  OP_ORI, 6'd0, 1'b0, 1'b1, V_IMMWB);
        check("ori_off_once", {15'd0, bus1.illegal, bus1.regwrite},
              17'b00);
        step("ori_done",   OP_ORI, 6'd0, 1'b0, 1'b1, V_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ENABLE_BNE, default 1, meaning: bne opcode is executed; when 0 it is treated as illegal.
REQ-002 Parameter ENABLE_ZEROIMM, default 1, meaning: andi/ori are executed with a zero-extended immediate; when 0 they are treated as illegal.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 op, funct  in  6 each  instruction fields from the instruction register.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory handshake: the access completes in a cycle where it is 1.
REQ-009 Outputs, 1 bit each: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, zeroimm, pcen, illegal.
REQ-010 Outputs alusrcb and pcsrc are 2 bits each; output alucontrol is 3 bits.

Function
REQ-011 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, IMMEX, IMMWB, JEX.
REQ-012 Opcode map: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, andi=001100, ori=001101, j=000010.
REQ-013 Outputs are combinational from the state and op; any signal not listed for a state is 0.
REQ-014 aluop encoding: 00=add, 01=sub, 10=decode funct, 11=logic selected by op[0].
REQ-015 pcen = pcwrite | (branch & zero) | (bne_s & ~zero).
REQ-016 FETCH: alusrcb=01, aluop=00; irwrite=pcwrite=1 only when mem_ready=1, then go to DECODE; otherwise hold FETCH.
REQ-017 DECODE: alusrcb=11, aluop=00; branch to MEMADR (lw/sw), RTYPEEX, BEQEX (beq or enabled bne), IMMEX (addi or enabled andi/ori), JEX, or FETCH (illegal).
REQ-018 MEMADR: alusrca=1, alusrcb=10; go to MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: iord=1; hold until mem_ready=1, then go to MEMWB.
REQ-020 MEMWB: memtoreg=1, regwrite=1; go to FETCH.
REQ-021 MEMWR: iord=1, memwrite=1 for every cycle of the state; hold until mem_ready=1, then go to FETCH.
REQ-022 RTYPEEX: alusrca=1, aluop=10, then RTYPEWB; RTYPEWB: regdst=1, regwrite=1, then FETCH.
REQ-023 BEQEX: alusrca=1, aluop=01, pcsrc=01; branch=1 for beq, bne_s=1 for bne; then FETCH.
REQ-024 IMMEX: alusrca=1, alusrcb=10; aluop=00 for addi; aluop=11 and zeroimm=1 for andi/ori; then IMMWB.
REQ-025 IMMWB: regwrite=1, regdst=0, memtoreg=0; zeroimm held as in IMMEX; then FETCH.
REQ-026 JEX: pcsrc=10, pcwrite=1; then FETCH.
REQ-027 alucontrol: add=010, sub=110, and=000, or=001, slt=111.
REQ-028 funct decode: 100000=add, 100010=sub, 100100=and, 100101=or, 101010=slt; any other funct gives 010 with no other side effect.
REQ-029 illegal is a registered output: it pulses 1 for exactly one cycle, the cycle after DECODE sees an unsupported opcode.
REQ-030 An illegal instruction produces no regwrite, memwrite or pcen beyond its FETCH.
REQ-031 Instruction latencies with mem_ready held at 1: lw=5 cycles, sw=4, R/addi/andi/ori=4, beq/bne/j=3.

Reset
REQ-032 While reset_n=0: state=FETCH, illegal=0, and memwrite, irwrite, regwrite and pcen are forced to 0 regardless of mem_ready.
REQ-033 Reset mid-instruction aborts it immediately; the first cycle after release is FETCH.

Structure
REQ-034 Package mips_pkg holds: opcode and funct constants, the state enum, the aluop and alucontrol encodings.
REQ-035 Sub-module mc_aludec (inputs funct, aluop, op[0]; output alucontrol) is instantiated once.
REQ-036 The state register, next-state logic and output decode live in mc_controller.

Verification
REQ-037 Reset, lw (100011), mem_ready always 1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-038 sw with mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH.
REQ-039 beq with zero=1 -> pcen=1 in BEQEX; bne with zero=1 -> pcen=0; bne with zero=0 -> pcen=1.
REQ-040 ori (001101) -> alucontrol=001 and zeroimm=1 in IMMEX and IMMWB; rebuild with ENABLE_ZEROIMM=0 -> illegal pulses once, regwrite stays 0.
REQ-041 reset_n low in RTYPEEX -> all write enables 0 asynchronously; FETCH on release; undefined op 111111 -> illegal pulses one cycle, then FETCH.
